// File: rtl/sysbus_pkg.sv
// Shared definitions for the I/D cache system-bus arbiter: tag-field codes,
// arbiter state encoding and client identifiers.
package sysbus_pkg;

    localparam int SYSBUS_DATA_WIDTH = 64;
    localparam int SYSBUS_TAG_WIDTH  = 13;

    // Request-type codes carried in reqtag[11:8].
    localparam logic [3:0] SYSBUS_READ   = 4'h1;
    localparam logic [3:0] SYSBUS_WRITE  = 4'h2;
    localparam logic [3:0] SYSBUS_MEMORY = 4'h4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADDR    = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_WR_DATA = 2'd3
    } arb_state_e;

    typedef enum logic {
        CLIENT_I = 1'b0,
        CLIENT_D = 1'b1
    } client_e;

endpackage

// File: rtl/sysbus_if.sv
// One system-bus channel; used for each cache client and for the shared bus.
interface sysbus_if #(
    parameter int BUS_DATA_WIDTH = sysbus_pkg::SYSBUS_DATA_WIDTH,
    parameter int BUS_TAG_WIDTH  = sysbus_pkg::SYSBUS_TAG_WIDTH
);
    // reqcyc is the requester's valid; it holds req/reqtag stable until the
    // responder pulses reqack. respcyc marks each response beat on resp/resptag,
    // and the requester returns respack for every beat it takes.
    logic                      reqcyc;
    logic [BUS_DATA_WIDTH-1:0] req;
    logic [BUS_TAG_WIDTH-1:0]  reqtag;
    logic                      respack;
    logic                      reqack;
    logic                      respcyc;
    logic [BUS_DATA_WIDTH-1:0] resp;
    logic [BUS_TAG_WIDTH-1:0]  resptag;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/sysbus_rr_picker.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// client that did not win last.
module sysbus_rr_picker
    import sysbus_pkg::*;
(
    input  logic    req_i,
    input  logic    req_d,
    input  client_e last_grant,
    output client_e grant
);
    always_comb begin
        grant = CLIENT_I;
        if (req_d && (!req_i || last_grant == CLIENT_I)) begin
            grant = CLIENT_D;
        end
    end
endmodule

// File: rtl/sysbus_arbiter.sv
// Grants the system bus to the I or D cache for one line transaction and
// routes the bus to the owner only; response data is broadcast to both.
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = SYSBUS_DATA_WIDTH,
    parameter int BUS_TAG_WIDTH  = SYSBUS_TAG_WIDTH,
    parameter int BEATS          = 8
) (
    input  logic       clk,
    input  logic       reset,
    sysbus_if.slave    client_i,
    sysbus_if.slave    client_d,
    sysbus_if.master   bus,
    output arb_state_e dbg_state
);
    localparam int BEAT_W = $clog2(BEATS + 1);

    arb_state_e                state;
    client_e                   owner;
    client_e                   last_grant;
    client_e                   pick;
    logic [BEAT_W-1:0]         beat;
    logic [BEAT_W-1:0]         beat_next;
    logic                      is_write;
    logic                      active;
    logic                      own_reqcyc;
    logic                      own_respack;
    logic [BUS_DATA_WIDTH-1:0] own_req;
    logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
    logic [BUS_TAG_WIDTH-1:0]  pick_tag;

    sysbus_rr_picker u_picker (
        .req_i      (client_i.reqcyc),
        .req_d      (client_d.reqcyc),
        .last_grant (last_grant),
        .grant      (pick)
    );

    always_comb begin
        own_reqcyc  = client_i.reqcyc;
        own_req     = client_i.req;
        own_reqtag  = client_i.reqtag;
        own_respack = client_i.respack;
        if (owner == CLIENT_D) begin
            own_reqcyc  = client_d.reqcyc;
            own_req     = client_d.req;
            own_reqtag  = client_d.reqtag;
            own_respack = client_d.respack;
        end
    end

    assign pick_tag  = (pick == CLIENT_D) ? client_d.reqtag : client_i.reqtag;
    // Saturate rather than wrap so an over-long read burst cannot alias to zero.
    assign beat_next = (beat == BEAT_W'(BEATS)) ? beat : beat + BEAT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            owner      <= CLIENT_I;
            last_grant <= CLIENT_I;
            beat       <= '0;
            is_write   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (client_i.reqcyc || client_d.reqcyc) begin
                        owner    <= pick;
                        is_write <= (pick_tag[11:8] == SYSBUS_WRITE);
                        beat     <= '0;
                        state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // A withdrawn request never counts as a grant for fairness.
                    if (!own_reqcyc) begin
                        state <= ST_IDLE;
                    end else if (bus.reqack) begin
                        last_grant <= owner;
                        state      <= is_write ? ST_WR_DATA : ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (bus.respcyc) begin
                        beat <= beat_next;
                    end else if (beat != '0) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WR_DATA: begin
                    if (own_reqcyc) begin
                        beat <= beat_next;
                        if (beat_next == BEAT_W'(BEATS)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign active = (state != ST_IDLE);

    assign bus.reqcyc  = active && own_reqcyc;
    assign bus.req     = active ? own_req : '0;
    assign bus.reqtag  = active ? own_reqtag : '0;
    assign bus.respack = active && own_respack;

    assign client_i.reqack  = active && (owner == CLIENT_I) && bus.reqack;
    assign client_i.respcyc = active && (owner == CLIENT_I) && bus.respcyc;
    assign client_d.reqack  = active && (owner == CLIENT_D) && bus.reqack;
    assign client_d.respcyc = active && (owner == CLIENT_D) && bus.respcyc;

    assign client_i.resp    = bus.resp;
    assign client_i.resptag = bus.resptag;
    assign client_d.resp    = bus.resp;
    assign client_d.resptag = bus.resptag;

    assign dbg_state = state;
endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
- Arbitrates the single system bus between the instruction cache (client I) and the data cache (client D). Sits directly downstream of both caches' bus interfaces.
- Grants one client per transaction: an address phase, then an 8-beat (64-byte line) read response or write data burst.
- Forwards the granted client's signals to the bus and routes the bus back to that client only.

Parameters:
- BUS_DATA_WIDTH, 64, width of req/resp data
- BUS_TAG_WIDTH, 13, width of req/resp tag
- BEATS, 8, data beats per line transaction

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
- i_reqcyc  in  1  client I request valid
- i_req  in  BUS_DATA_WIDTH  client I address/data
- i_reqtag  in  BUS_TAG_WIDTH  client I request tag
- i_respack  in  1  client I response-beat acknowledge
- i_reqack  out  1  bus reqack routed to I
- i_respcyc  out  1  bus respcyc routed to I
- i_resp  out  BUS_DATA_WIDTH  bus resp (broadcast)
- i_resptag  out  BUS_TAG_WIDTH  bus resptag (broadcast)
- d_reqcyc, d_req, d_reqtag, d_respack, d_reqack, d_respcyc, d_resp, d_resptag  (same as I, for client D)
- bus_reqcyc  out  1  to system bus
- bus_req  out  BUS_DATA_WIDTH  to system bus
- bus_reqtag  out  BUS_TAG_WIDTH  to system bus
- bus_respack  out  1  to system bus
- bus_reqack  in  1  from system bus
- bus_respcyc  in  1  from system bus
- bus_resp  in  BUS_DATA_WIDTH  from system bus
- bus_resptag  in  BUS_TAG_WIDTH  from system bus

Behaviour:
- State: IDLE, ADDR, RD_DATA, WR_DATA. Registers: owner (I/D), last_grant (I/D), beat counter (0..BEATS), is_write.
- Reset (reset==0): state=IDLE, owner=I, last_grant=I, beat=0. All bus_* outputs 0. All client reqack/respcyc 0. Mid-transaction reset abandons the transfer with no completion to the client.
- IDLE:
  - If exactly one client has reqcyc=1, latch it as owner.
  - If both do, grant the one != last_grant; after reset D wins the first tie.
  - Latch is_write = (reqtag[11:8] == SYSBUS_WRITE).
  - Go to ADDR; beat=0.
  - bus_reqcyc=0 in IDLE, so there is 1 cycle of arbitration latency.
- Routing, states ADDR/RD_DATA/WR_DATA:
  - bus_reqcyc/bus_req/bus_reqtag/bus_respack = owner's inputs.
  - owner's reqack/respcyc = bus_reqack/bus_respcyc; the non-owner's reqack/respcyc are forced to 0.
  - *_resp and *_resptag are broadcast to both clients regardless of owner.
- ADDR: on bus_reqack==1, set last_grant=owner and go to WR_DATA if is_write, else RD_DATA. If owner drops reqcyc before reqack, return to IDLE; last_grant is unchanged.
- RD_DATA:
  - Count a beat each cycle with bus_respcyc==1.
  - Once beat>=1, the first cycle with bus_respcyc==0 returns to IDLE (release). A short burst is not an error.
- WR_DATA:
  - Count a beat each cycle with owner reqcyc==1.
  - The cycle the BEATS-th beat is counted returns to IDLE.
  - If owner reqcyc drops early, hold state and wait.
- Re-arbitration: the cycle after returning to IDLE. Back-to-back transactions therefore carry at least one idle bus cycle.
- A request arriving from the non-owner during a transaction is held pending by the client (reqcyc stays high) and sees no reqack.
- Beat counter saturates at BEATS; it does not wrap.

Decomposition:
- Shared package sysbus_pkg: SYSBUS_READ, SYSBUS_WRITE and SYSBUS_MEMORY tag-field constants, plus the arbiter state enum and the client-id typedef.
- One sub-module is natural: sysbus_rr_picker, a 2-way round-robin selector (req_i, req_d, last_grant -> grant).

Test Plan:
- Read, single client: D reqcyc with req=0x1000 (read tag); bus acks 2 cycles later, then 8 beats 0x11..0x88 -> bus_req=0x1000 one cycle after d_reqcyc, d_respcyc high for exactly 8 beats with matching data, i_respcyc=0 throughout, return to IDLE.
- Write burst: D write tag, addr 0x2040; after reqack, D drives 8 beats 0xA0..0xA7 -> bus_req shows address then 0xA0..0xA7 in order; release after the 8th beat.
- Tie after reset: I and D request in the same cycle -> D granted first. When D releases, I granted the following cycle. A second tie then goes to D.
- Non-owner isolation: D owns a read; I raises reqcyc with 0x3000 mid-burst -> bus_req never shows 0x3000 until D releases; i_reqack=0 meanwhile.
- Early drop: owner drops reqcyc in ADDR before reqack -> IDLE next cycle, last_grant unchanged, bus_reqcyc=0.
- Reset mid-read: assert reset (0) at beat 4 -> next cycle all bus_* outputs 0, state IDLE. A new D read after reset release completes normally.
